// File: rtl/hilo_div_unit.sv
// HI/LO register file with an iterative restoring divider (MIPS div/divu).
// Produces one quotient bit per cycle, then commits quotient to LO and remainder to HI.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_busy,
  output logic             div_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shift_w;
  logic             ge_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    // Shift-in and compare carry an extra MSB so a partial remainder >= 2^(WIDTH-1) is not lost.
    shift_w = {rem_q, quo_q[WIDTH-1]};
    ge_w    = (shift_w >= {1'b0, dvs_q});

    unique case (state_q)
      S_IDLE: begin
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start && !abort) begin
          state_d = S_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (is_signed && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
          dvs_d   = (is_signed && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
          q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = is_signed && dividend[WIDTH-1];
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // The subtracted result is always below the divisor, so WIDTH bits suffice.
          rem_d = ge_w ? (shift_w[WIDTH-1:0] - dvs_q) : shift_w[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge_w};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          lo_d   = q_neg_q ? ('0 - quo_q) : quo_q;
          hi_d   = r_neg_q ? ('0 - rem_q) : rem_q;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_busy = (state_q != S_IDLE);
  assign div_done = done_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_hilo_div_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, is_signed, abort, mthi_we, mtlo_we;
  logic [W-1:0] dividend, divisor, wdata;
  logic [W-1:0] hi, lo;
  logic         div_busy, div_done;

  int checks   = 0;
  int failures = 0;

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .abort    (abort),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .div_busy (div_busy),
    .div_done (div_done)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference result from plain magnitude arithmetic and the sign fix-up rules.
  function automatic void ref_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sgn,
                                  output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    logic [63:0] a, b, q, r;
    logic qn, rn;
    a  = (sgn && dd[W-1]) ? 64'h1_0000_0000 - {32'd0, dd} : {32'd0, dd};
    b  = (sgn && dv[W-1]) ? 64'h1_0000_0000 - {32'd0, dv} : {32'd0, dv};
    qn = sgn && (dd[W-1] != dv[W-1]);
    rn = sgn && dd[W-1];
    if (b == 0) begin
      q = 64'h0000_0000_FFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    rlo = qn ? W'(64'd0 - q) : q[W-1:0];
    rhi = rn ? W'(64'd0 - r) : r[W-1:0];
  endfunction

  // Model: remembers whether a divide is pending and how many edges remain before commit.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_busy, m_done;
  int           m_left;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (mthi_we) m_hi = wdata;
        if (mtlo_we) m_lo = wdata;
        if (start && !abort) begin
          ref_div(dividend, divisor, is_signed, p_hi, p_lo);
          m_busy = 1'b1;
          m_left = 33;
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_hi",   hi,               m_hi);
    chk("cyc_lo",   lo,               m_lo);
    chk("cyc_busy", {31'd0, div_busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, div_done}, {31'd0, m_done});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sgn);
    start = 1'b1; dividend = dd; divisor = dv; is_signed = sgn;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (div_busy && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, div_busy}, 32'd0);
    step();
  endtask

  task automatic div_and_check(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                               input logic sgn, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    drive_start(dd, dv, sgn);
    wait_idle();
    chk({name, "_lo"}, lo, exp_lo);
    chk({name, "_hi"}, hi, exp_hi);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; abort = 1'b0;
    mthi_we = 1'b0; mtlo_we = 1'b0; dividend = '0; divisor = '0; wdata = '0;
    step(); step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    reset = 1'b0;
    step();

    // divu 100/7 with exact timing: accepted at edge 0, commit at edge 33.
    drive_start(32'd100, 32'd7, 1'b0);
    chk("t1_busy_c1", {31'd0, div_busy}, 32'd1);
    repeat (31) step();
    step();
    chk("t1_busy_c33", {31'd0, div_busy}, 32'd1);
    chk("t1_lo_before", lo, 32'd0);
    chk("t1_hi_before", hi, 32'd0);
    step();
    chk("t1_busy_c34", {31'd0, div_busy}, 32'd0);
    chk("t1_done", {31'd0, div_done}, 32'd1);
    chk("t1_lo", lo, 32'd14);
    chk("t1_hi", hi, 32'd2);
    step();
    chk("t1_done_off", {31'd0, div_done}, 32'd0);

    div_and_check("neg7_2",  32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_and_check("7_neg2",  32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001);
    div_and_check("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000);
    div_and_check("divu5_0", 32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5);
    div_and_check("div_n5_0", 32'hFFFF_FFFB, 32'd0,        1'b1, 32'h0000_0001, 32'hFFFF_FFFB);
    div_and_check("divu_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'h0000_0001, 32'h7FFF_FFFE);

    // Second start while busy is ignored.
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (9) step();
    drive_start(32'd9, 32'd3, 1'b0);
    wait_idle();
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    // mthi/mtlo in IDLE, then mtlo while busy is dropped.
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_AAAA;
    step();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt_hi", hi, 32'h0000_AAAA);
    chk("mt_lo", lo, 32'h0000_AAAA);
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (4) step();
    mtlo_we = 1'b1; wdata = 32'h0000_1234;
    step();
    mtlo_we = 1'b0;
    step();
    chk("busy_mt_lo", lo, 32'h0000_AAAA);
    chk("busy_mt_hi", hi, 32'h0000_AAAA);
    wait_idle();
    chk("mt_commit_lo", lo, 32'd14);
    chk("mt_commit_hi", hi, 32'd2);

    // mtlo together with an accepted start: visible next cycle, then overwritten.
    mtlo_we = 1'b1; wdata = 32'h0000_0077;
    drive_start(32'd9, 32'd3, 1'b0);
    mtlo_we = 1'b0;
    chk("mtsim_lo", lo, 32'h0000_0077);
    wait_idle();
    chk("mtsim_commit_lo", lo, 32'd3);
    chk("mtsim_commit_hi", hi, 32'd0);

    // Abort at cycle 12: no commit, no done.
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (11) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'd0, div_busy}, 32'd0);
    repeat (30) step();
    chk("abort_lo", lo, 32'd3);
    chk("abort_hi", hi, 32'd0);

    // Abort in IDLE overrides a simultaneous start.
    abort = 1'b1;
    drive_start(32'd50, 32'd5, 1'b0);
    abort = 1'b0;
    chk("abort_idle_busy", {31'd0, div_busy}, 32'd0);
    repeat (36) step();
    chk("abort_idle_lo", lo, 32'd3);

    // Reset at cycle 20 of a divide.
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (19) step();
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, div_busy}, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    step();
    reset = 1'b0;
    repeat (40) step();
    chk("postrst_lo", lo, 32'd0);
    chk("postrst_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative 32-bit MIPS divider (div/divu) owning the HI/LO registers; sits in the Execute stage.
- Accepts a divide from E, runs 1 quotient bit/cycle, then commits the quotient to LO and the remainder to HI.
- Also services mthi/mtlo and drives hi/lo to the mfhi/mflo path.
- div_busy feeds the hazard unit's has-divide logic so mfhi/mflo in Decode stall until the result is committed.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage div/divu is valid and not being flushed; sampled on the clock edge.
- is_signed  in  1  1 = div, 0 = divu; sampled with start.
- dividend  in  WIDTH  rs value after forwarding.
- divisor  in  WIDTH  rt value after forwarding.
- abort  in  1  cancel the in-flight divide (exception/flush).
- mthi_we  in  1  write HI from wdata.
- mtlo_we  in  1  write LO from wdata.
- wdata  in  WIDTH  mthi/mtlo data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_busy  out  1  divide in flight; HI/LO not final.
- div_done  out  1  one-cycle pulse when HI/LO commit.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, div_busy=0, div_done=0, all internal registers 0.
- States:
  - IDLE: if start=1 at edge N, latch operands and go to RUN with cnt=0.
    - Signed: capture abs(dividend), abs(divisor), q_neg=sign(dividend)^sign(divisor), r_neg=sign(dividend).
    - Unsigned: q_neg=r_neg=0.
  - RUN: restoring step each edge.
    - rem={rem[WIDTH-2:0],quo[WIDTH-1]}; quo<<=1.
    - If rem>=divisor: rem-=divisor, quo[0]=1.
    - The shift-in and compare are done on WIDTH+1 bits so no carry is lost.
    - cnt++; after the WIDTH-th step (edge N+32) go to FIX.
  - FIX: at edge N+33:
    - lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem.
    - Go to IDLE; div_done=1 for exactly the cycle after edge N+33.
- div_busy is registered: 1 whenever state!=IDLE, i.e. cycles N+1..N+33; it falls in the same cycle div_done rises.
- Total latency: 34 edges from accept to visible HI/LO.
- start while busy: ignored; the in-flight divide continues unchanged.
- abort while busy: next edge state=IDLE, div_busy=0, no commit, hi/lo unchanged, div_done=0.
- abort in IDLE: no effect, and it overrides a simultaneous start (nothing accepted).
- Divide by zero (divisor=0): no exception. The algorithm naturally yields unsigned lo=all-ones, hi=dividend. Signed results follow the sign fix-up rules; bench must match the fix-up model.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. abs() is taken as unsigned, so there is no trap.
- mthi_we/mtlo_we:
  - In IDLE: write on the edge; the value is visible next cycle.
  - While busy: ignored; the divide result wins at commit.
  - Simultaneous with an accepted start: the mt write takes effect, then is overwritten at commit.
- hi/lo outputs are register values only, never mid-computation values.
- Reset mid-operation: immediately IDLE, hi=lo=0, busy=0; no pending commit after reset releases.

Test Plan:
- divu 100/7, start at edge 0 → div_busy high cycles 1–33; after edge 33 lo=14, hi=2, div_done pulse one cycle; hi/lo unchanged before edge 33.
- div -7/2 (0xFFFFFFF9, 0x00000002) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 7/-2 → lo=0xFFFFFFFD, hi=0x00000001.
- div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. divu 5/0 → lo=0xFFFFFFFF, hi=5.
- Start divu 100/7, second start 9/3 at cycle 10 → second ignored; final lo=14, hi=2.
- mthi 0xAAAA in IDLE then start divu 100/7 → hi=0xAAAA until commit, then 2. mtlo at cycle 5 while busy → ignored.
- abort at cycle 12 → busy low from cycle 13, hi/lo keep prior values, no div_done. Reset asserted at cycle 20 of a divide → hi=lo=0, busy=0 immediately, no later commit.
